// File: rtl/alu_pkg.sv
// Shared op encoding and element-size helpers for the ALU lane selector.
// ALU_LANE_SEL_CHK_EN enables the illegal-op check in alu_lane_sel.
package alu_pkg;

    typedef enum logic [6:0] {
        ALU_N   = 7'h00,
        ALU_B   = 7'h01,
        ALU_H   = 7'h02,
        ALU_W   = 7'h03,
        ALU_BFP = 7'h04
    } op_e;

    // log2 of element size in bytes; unknown ops behave as ALU_N
    function automatic logic [1:0] elem_lg(logic [6:0] op);
        logic [1:0] lg;
        lg = 2'd0;
        unique case (op)
            ALU_B:   lg = 2'd1;
            ALU_H:   lg = 2'd2;
            ALU_W:   lg = 2'd3;
            default: lg = 2'd0;
        endcase
        return lg;
    endfunction

    function automatic logic op_legal(logic [6:0] op);
        return (op == ALU_N) || (op == ALU_B) || (op == ALU_H) ||
               (op == ALU_W) || (op == ALU_BFP);
    endfunction

endpackage

// File: rtl/alu_lane_sel_if.sv
// Request/result bundle for alu_lane_sel.
// master drives requests and consumes results; slave is the selector.
interface alu_lane_sel_if #(
    parameter int NUM_BYTES = 8
);
    localparam int SEL_W = $clog2(NUM_BYTES);

    logic                       in_valid;
    logic                       in_ready;
    logic [6:0]                 in_op;
    logic [NUM_BYTES*SEL_W-1:0] in_sel;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_BYTES*SEL_W-1:0] out_sel;
    logic [6:0]                 out_op;
    logic                       err;

    modport master (
        output in_valid, in_op, in_sel, out_ready,
        input  in_ready, out_valid, out_sel, out_op, err
    );

    modport slave (
        input  in_valid, in_op, in_sel, out_ready,
        output in_ready, out_valid, out_sel, out_op, err
    );

endinterface

// File: rtl/alu_lane_expand.sv
// Expands per-element selects into per-byte selects.
// Byte j = (element select << log2(E)) | (j mod E), truncated to SEL_W.
module alu_lane_expand
    import alu_pkg::*;
#(
    parameter int NUM_BYTES = 8,
    localparam int SEL_W = $clog2(NUM_BYTES)
) (
    input  logic [6:0]                 i_op,
    input  logic [NUM_BYTES*SEL_W-1:0] i_sel,
    output logic [NUM_BYTES*SEL_W-1:0] o_sel
);

    always_comb begin
        int lg;
        int idx;
        int ent;
        o_sel = '0;
        lg    = int'(elem_lg(i_op));
        idx   = 0;
        ent   = 0;
        if (lg > SEL_W) lg = SEL_W;
        for (int j = 0; j < NUM_BYTES; j++) begin
            idx = j >> lg;
            ent = int'(i_sel[idx*SEL_W +: SEL_W]);
            o_sel[j*SEL_W +: SEL_W] =
                SEL_W'((ent << lg) | (j & ((1 << lg) - 1)));
        end
    end

endmodule

// File: rtl/alu_lane_sel.sv
// Two-stage valid/ready pipeline around alu_lane_expand.
// ALU_LANE_SEL_CHK_EN: flag illegal ops, zero their selects, sticky err_o.
module alu_lane_sel
    import alu_pkg::*;
#(
    parameter int NUM_BYTES = 8,
    localparam int SEL_W = $clog2(NUM_BYTES)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [6:0]                 in_op_i,
    input  logic [NUM_BYTES*SEL_W-1:0] in_sel_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_BYTES*SEL_W-1:0] out_sel_o,
    output logic [6:0]                 out_op_o,
    output logic                       err_o
);

    logic                       r_s1_valid;
    logic [6:0]                 r_s1_op;
    logic [NUM_BYTES*SEL_W-1:0] r_s1_sel;
    logic                       r_s2_valid;
    logic [6:0]                 r_s2_op;
    logic [NUM_BYTES*SEL_W-1:0] r_s2_sel;

    logic                       w_s2_ready;
    logic                       w_s1_adv;
    logic                       w_in_fire;
    logic [NUM_BYTES*SEL_W-1:0] w_exp_sel;
    logic [NUM_BYTES*SEL_W-1:0] w_s2_sel;

    assign w_s2_ready = !r_s2_valid || out_ready_i;
    assign w_s1_adv   = r_s1_valid && w_s2_ready;
    assign in_ready_o = !r_s1_valid || w_s1_adv;
    assign w_in_fire  = in_valid_i && in_ready_o;

    alu_lane_expand #(
        .NUM_BYTES (NUM_BYTES)
    ) u_expand (
        .i_op  (r_s1_op),
        .i_sel (r_s1_sel),
        .o_sel (w_exp_sel)
    );

`ifdef ALU_LANE_SEL_CHK_EN
    logic r_s1_bad;
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_bad <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_in_fire) r_s1_bad <= !op_legal(in_op_i);
            if (w_s1_adv && r_s1_bad) r_err <= 1'b1;
        end
    end

    assign w_s2_sel = r_s1_bad ? '0 : w_exp_sel;
    assign err_o    = r_err;
`else
    assign w_s2_sel = w_exp_sel;
    assign err_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_sel   <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= in_op_i;
            r_s1_sel   <= in_sel_i;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // stage 2 only reloads when free or being consumed, so stalls hold it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= '0;
            r_s2_sel   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_op  <= r_s1_op;
                r_s2_sel <= w_s2_sel;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign out_sel_o   = r_s2_sel;
    assign out_op_o    = r_s2_op;

endmodule

// File: tb/tb_alu_lane_sel.sv
// Directed + random bench for alu_lane_sel with a queue-based reference.
// Build with +define+ALU_LANE_SEL_CHK_EN to exercise the illegal-op check.
module tb_alu_lane_sel;
    import alu_pkg::*;

    localparam int NB = 8;
    localparam int SW = 3;
    localparam int W  = NB * SW;

    typedef struct {
        logic [6:0]   op;
        logic [W-1:0] sel;
        logic         bad;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    beat_t        q[$];
    logic         err_seen;
    logic         hold_pend;
    logic [W-1:0] hold_sel;
    logic [6:0]   hold_op;

    alu_lane_sel_if #(.NUM_BYTES(NB)) bus ();

    alu_lane_sel #(
        .NUM_BYTES (NB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_op_i     (bus.in_op),
        .in_sel_i    (bus.in_sel),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_sel_o   (bus.out_sel),
        .out_op_o    (bus.out_op),
        .err_o       (bus.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk8(int b0, int b1, int b2, int b3,
                                         int b4, int b5, int b6, int b7);
        logic [W-1:0] r;
        r = {SW'(b7), SW'(b6), SW'(b5), SW'(b4),
             SW'(b3), SW'(b2), SW'(b1), SW'(b0)};
        return r;
    endfunction

    function automatic logic is_legal(logic [6:0] op);
        return op inside {ALU_N, ALU_B, ALU_H, ALU_W, ALU_BFP};
    endfunction

    // Byte j reads element j/E, and lands on byte (sel*E + j%E) mod NB
    function automatic logic [W-1:0] model(logic [6:0] op, logic [W-1:0] sel);
        logic [W-1:0] r;
        int e;
        int ent;
        r = '0;
        case (op)
            ALU_B:   e = 2;
            ALU_H:   e = 4;
            ALU_W:   e = 8;
            default: e = 1;
        endcase
        if (e > NB) e = NB;
`ifdef ALU_LANE_SEL_CHK_EN
        if (!is_legal(op)) return '0;
`endif
        for (int j = 0; j < NB; j++) begin
            ent = int'(sel[(j / e) * SW +: SW]);
            r[j*SW +: SW] = SW'((ent * e + j % e) % NB);
        end
        return r;
    endfunction

    // Drive one cycle at a negedge, check before the posedge, return at negedge
    task automatic tick(input logic v, input logic [6:0] op,
                        input logic [W-1:0] sel, input logic rdy);
        beat_t b;
        logic  in_fire;
        logic  out_fire;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_sel    = sel;
        bus.out_ready = rdy;
        #1;
        chk("in_ready", {63'd0, bus.in_ready},
            {63'd0, (q.size() < 2) || rdy});
        if (q.size() == 0)
            chk("out_valid_idle", {63'd0, bus.out_valid}, 64'd0);
        if (q.size() == 2)
            chk("out_valid_full", {63'd0, bus.out_valid}, 64'd1);
        if (hold_pend) begin
            chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("hold_sel", {40'd0, bus.out_sel}, {40'd0, hold_sel});
            chk("hold_op", {57'd0, bus.out_op}, {57'd0, hold_op});
        end
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_sel  = bus.out_sel;
        hold_op   = bus.out_op;
        if (out_fire && q.size() > 0) begin
            b = q.pop_front();
            if (b.bad) err_seen = 1'b1;
            chk("out_sel", {40'd0, bus.out_sel}, {40'd0, b.sel});
            chk("out_op", {57'd0, bus.out_op}, {57'd0, b.op});
            chk("err", {63'd0, bus.err}, {63'd0, err_seen});
        end
        if (in_fire) begin
            b.op  = op;
            b.sel = model(op, sel);
`ifdef ALU_LANE_SEL_CHK_EN
            b.bad = !is_legal(op);
`else
            b.bad = 1'b0;
`endif
            q.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 7'd0, '0, 1'b1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            tick(1'b0, 7'd0, '0, 1'b1);
            guard++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    initial begin
        logic [W-1:0] rsel;
        logic [6:0]   rop;
        int           pick;
        n_checks  = 0;
        n_errors  = 0;
        err_seen  = 1'b0;
        hold_pend = 1'b0;
        hold_sel  = '0;
        hold_op   = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_sel", {40'd0, bus.out_sel}, 64'd0);
        chk("rst_out_op", {57'd0, bus.out_op}, 64'd0);
        chk("rst_err", {63'd0, bus.err}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);

        // ALU_N reverse, with two-cycle latency
        tick(1'b1, ALU_N, mk8(7, 6, 5, 4, 3, 2, 1, 0), 1'b1);
        tick(1'b0, 7'd0, '0, 1'b1);
        chk("lat_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("n_const", {40'd0, bus.out_sel},
            {40'd0, mk8(7, 6, 5, 4, 3, 2, 1, 0)});
        drain();

        tick(1'b1, ALU_B, mk8(3, 2, 1, 0, 0, 0, 0, 0), 1'b1);
        tick(1'b0, 7'd0, '0, 1'b1);
        chk("b_const", {40'd0, bus.out_sel},
            {40'd0, mk8(6, 7, 4, 5, 2, 3, 0, 1)});
        drain();

        tick(1'b1, ALU_H, mk8(1, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        tick(1'b1, ALU_W, mk8(5, 3, 1, 7, 2, 2, 6, 4), 1'b1);
        chk("h_const", {40'd0, bus.out_sel},
            {40'd0, mk8(4, 5, 6, 7, 0, 1, 2, 3)});
        tick(1'b0, 7'd0, '0, 1'b1);
        chk("w_const", {40'd0, bus.out_sel},
            {40'd0, mk8(0, 1, 2, 3, 4, 5, 6, 7)});
        drain();

        // Three beats against a 5-cycle stall
        tick(1'b1, ALU_N, mk8(1, 1, 1, 1, 1, 1, 1, 1), 1'b0);
        tick(1'b1, ALU_B, mk8(2, 2, 2, 2, 2, 2, 2, 2), 1'b0);
        for (int i = 0; i < 3; i++)
            tick(1'b1, ALU_H, mk8(3, 3, 3, 3, 3, 3, 3, 3), 1'b0);
        chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("stall_q", 64'(q.size()), 64'd2);
        tick(1'b1, ALU_H, mk8(3, 3, 3, 3, 3, 3, 3, 3), 1'b1);
        chk("burst2_valid", {63'd0, bus.out_valid}, 64'd1);
        tick(1'b0, 7'd0, '0, 1'b1);
        chk("burst3_valid", {63'd0, bus.out_valid}, 64'd1);
        tick(1'b0, 7'd0, '0, 1'b1);
        chk("burst_q", 64'(q.size()), 64'd0);

        // Reset with both stages full
        tick(1'b1, ALU_W, mk8(1, 2, 3, 4, 5, 6, 7, 0), 1'b0);
        tick(1'b1, ALU_B, mk8(7, 7, 7, 7, 7, 7, 7, 7), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_out_sel", {40'd0, bus.out_sel}, 64'd0);
        q.delete();
        hold_pend = 1'b0;
        err_seen  = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Undefined op
        tick(1'b1, 7'h55, mk8(7, 6, 5, 4, 3, 2, 1, 0), 1'b1);
        drain();
`ifdef ALU_LANE_SEL_CHK_EN
        chk("err_set", {63'd0, bus.err}, 64'd1);
`else
        chk("err_tied", {63'd0, bus.err}, 64'd0);
`endif
        tick(1'b1, ALU_N, mk8(0, 1, 2, 3, 4, 5, 6, 7), 1'b1);
        drain();
        chk("err_sticky", {63'd0, bus.err}, {63'd0, err_seen});

        // Random traffic and back-pressure
        for (int i = 0; i < 400; i++) begin
            rsel = W'({$urandom, $urandom});
            pick = int'($urandom_range(0, 15));
            case (pick % 5)
                0: rop = ALU_N;
                1: rop = ALU_B;
                2: rop = ALU_H;
                3: rop = ALU_W;
                default: rop = ALU_BFP;
            endcase
            if (pick == 15) rop = 7'($urandom_range(5, 127));
            tick($urandom_range(0, 3) != 0, rop, rsel,
                 $urandom_range(0, 2) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_lane_sel.md
ALU_LANE_SEL -- requirements
Module: alu_lane_sel

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 8, lane (byte) count; power of two, >= 2.
REQ-002 SHALL have derived localparam SEL_W = $clog2(NUM_BYTES), the per-lane select width.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all flops on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_valid_i, input, 1, request valid.
REQ-006 SHALL have port in_ready_o, output, 1, request accepted when in_valid_i && in_ready_o.
REQ-007 SHALL have port in_op_i, input, 7 (op_e), element-width mode.
REQ-008 SHALL have port in_sel_i, input, NUM_BYTES x SEL_W packed, per-element selects; element k uses entry k.
REQ-009 SHALL have port out_valid_o, output, 1, result valid.
REQ-010 SHALL have port out_ready_i, input, 1, result consumed when out_valid_o && out_ready_i.
REQ-011 SHALL have port out_sel_o, output, NUM_BYTES x SEL_W packed, expanded per-byte selects.
REQ-012 SHALL have port out_op_o, output, 7, op of the result beat.
REQ-013 SHALL have port err_o, output, 1, sticky illegal-op flag.

Function
REQ-014 SHALL map ops to element size E bytes: ALU_N->1, ALU_B->2, ALU_H->4, ALU_W->8, ALU_BFP->1; E clamped to NUM_BYTES.
REQ-015 SHALL compute byte j: out_sel[j] = {in_sel[j/E][SEL_W-log2(E)-1:0], j[log2(E)-1:0]}; for E = NUM_BYTES the result is j.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers op/sel; stage 2 registers the expanded result; latency 2 cycles with out_ready_i high.
REQ-017 SHALL sustain one beat per cycle when not back-pressured.
REQ-018 SHALL advance stage 1 -> 2 when stage 2 is empty or out_ready_i=1; in_ready_o = !s1_valid || s1 advancing.
REQ-019 SHALL hold out_sel_o/out_op_o stable while out_valid_o && !out_ready_i.
REQ-020 SHALL preserve beat order; no beat dropped or duplicated under any stall pattern.
REQ-021 SHALL accept a new beat into stage 1 in the same cycle stage 1 drains into stage 2.
REQ-022 SHALL expand undefined op codes as ALU_N unless REQ-030 applies.

Reset
REQ-023 SHALL on rst_ni low immediately clear s1_valid, s2_valid, err_o; out_valid_o=0, in_ready_o=1 after reset release.
REQ-024 SHALL reset out_sel_o, out_op_o to zero.
REQ-025 SHALL discard in-flight beats on reset mid-operation; no beat emitted after release without a new request.

Configuration
REQ-026 SHALL provide macro ALU_LANE_SEL_CHK_EN.
REQ-027 SHALL, with the macro defined, flag any accepted op outside {ALU_N, ALU_B, ALU_H, ALU_W, ALU_BFP}.
REQ-028 SHALL, with the macro defined, set err_o when the flagged beat enters stage 2; err_o stays 1 until reset.
REQ-029 SHALL, with the macro defined, force out_sel_o of a flagged beat to all zero.
REQ-030 SHALL, without the macro, tie err_o to 0, compile out the check logic, and apply REQ-022.

Structure
REQ-031 SHALL place op_e (7-bit enum incl. ALU_W), the op->element-size function, and the legal-op predicate in package alu_pkg.
REQ-032 SHALL isolate the combinational expansion in sub-module alu_lane_expand (params NUM_BYTES; inputs op, sel; output expanded sel); pipeline/handshake stays in alu_lane_sel.

Verification (NUM_BYTES=8)
REQ-033 SHALL check: ALU_N, sel entries 7..0 (entry j = 7-j) -> after 2 cycles out bytes 0..7 = 7,6,5,4,3,2,1,0.
REQ-034 SHALL check: ALU_B, entries 0..3 = 3,2,1,0 -> out bytes 0..7 = 6,7,4,5,2,3,0,1.
REQ-035 SHALL check: ALU_H, entries 0,1 = 1,0 -> out bytes 0..7 = 4,5,6,7,0,1,2,3; ALU_W -> 0..7.
REQ-036 SHALL check: 3 back-to-back beats, out_ready_i low 5 cycles -> in_ready_o drops after 2 accepted, output held stable; on release all 3 emerge in order on consecutive cycles.
REQ-037 SHALL check: rst_ni low for 1 cycle with both stages full -> out_valid_o=0 asynchronously, nothing emitted after release.
REQ-038 SHALL check: op=7'h55 -> with ALU_LANE_SEL_CHK_EN, err_o=1 sticky and out_sel_o=0; without it, err_o=0 and output equals ALU_N expansion.
